mul_div_seq: RTL and testbench

- Multi-cycle unsigned 16x16 multiply and 16/16 divide sequencer.
- Acts as the initiator on the ALU operand/opcode interface (Ai/Bi/oper/CFi in, Qo/CF out). Reuses the ALU adder/subtractor each iteration instead of adding a dedicated datapath.
- Sits beside the ALU in the CPU execute stage. When busy, the execute mux hands it the ALU port.

---
 rtl/mul_div_seq_pkg.sv | 23 ++
 rtl/mul_div_seq_if.sv | 19 +
 rtl/mul_div_seq.sv | 150 +++++++++++++++
 tb/tb_mul_div_seq.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/mul_div_seq_pkg.sv
// Shared types and constants for the multi-cycle multiply/divide sequencer.
// The ALU opcodes here are also meant for the control-unit decoder.
package mul_div_pkg;

    localparam int unsigned WIDTH  = 16;
    localparam int unsigned ITER_W = 5;
    localparam int unsigned OPER_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [OPER_W-1:0] OP_ADD = 6'b010000;
    localparam logic [OPER_W-1:0] OP_SUB = 6'b011000;
    localparam logic [OPER_W-1:0] OP_NOP = 6'b000000;

    localparam logic OP_MULU = 1'b0;
    localparam logic OP_DIVU = 1'b1;

endpackage

// File: rtl/mul_div_seq_if.sv
// Request/result bundle between the execute stage and the mul/div sequencer.
interface mul_div_seq_if;
    import mul_div_pkg::*;

    logic             start;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] res_lo;
    logic [WIDTH-1:0] res_hi;
    logic             dz;

    modport master (output start, op, a, b,
                    input  busy, done, res_lo, res_hi, dz);
    modport slave  (input  start, op, a, b,
                    output busy, done, res_lo, res_hi, dz);
endinterface

// File: rtl/mul_div_seq.sv
// Unsigned 16x16 shift-add multiply and 16/16 restoring divide, one bit per
// cycle, borrowing the execute-stage ALU adder/subtractor for every iteration.
module mul_div_seq
    import mul_div_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    mul_div_seq_if.slave      bus,
    output logic [WIDTH-1:0]  alu_a,
    output logic [WIDTH-1:0]  alu_b,
    output logic [OPER_W-1:0] alu_oper,
    output logic              alu_wb,
    output logic              alu_cfi,
    input  logic [WIDTH-1:0]  alu_q,
    input  logic              alu_cf
);

    state_t state, state_nx;

    // opnd: multiplicand or divisor; hi/lo: {P_hi,P_lo} for MUL, {R,Q} for DIV
    logic [WIDTH-1:0]  opnd;
    logic [WIDTH-1:0]  hi;
    logic [WIDTH-1:0]  lo;
    logic [ITER_W-1:0] cnt;
    logic [WIDTH-1:0]  res_lo_q;
    logic [WIDTH-1:0]  res_hi_q;
    logic              dz_q;

    logic              accept;
    logic              div_zero;
    logic              last;
    logic [WIDTH-1:0]  div_s;
    logic              qbit;
    logic [WIDTH-1:0]  mul_hi_nx;
    logic [WIDTH-1:0]  mul_lo_nx;
    logic [WIDTH-1:0]  div_r_nx;
    logic [WIDTH-1:0]  div_q_nx;

    assign accept   = (state == IDLE) && bus.start;
    assign div_zero = (bus.op == OP_DIVU) && (bus.b == '0);
    assign last     = (cnt == ITER_W'(WIDTH - 1));

    // Iteration step; the ALU sum/difference is combinational in this cycle
    assign mul_hi_nx = lo[0] ? {alu_cf, alu_q[WIDTH-1:1]} : {1'b0, hi[WIDTH-1:1]};
    assign mul_lo_nx = lo[0] ? {alu_q[0], lo[WIDTH-1:1]}  : {hi[0], lo[WIDTH-1:1]};
    assign div_s     = {hi[WIDTH-2:0], lo[WIDTH-1]};
    // A set top bit means the shifted remainder exceeds 16 bits, so it always covers the divisor
    assign qbit      = hi[WIDTH-1] | ~alu_cf;
    assign div_r_nx  = qbit ? alu_q : div_s;
    assign div_q_nx  = {lo[WIDTH-2:0], qbit};

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (bus.op == OP_MULU) state_nx = MUL;
                    else if (div_zero)     state_nx = DONE;
                    else                   state_nx = DIV;
                end
            end
            MUL:     if (last) state_nx = DONE;
            DIV:     if (last) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state != IDLE);
        bus.done = (state == DONE);
        alu_a    = '0;
        alu_b    = '0;
        alu_oper = OP_NOP;
        case (state)
            MUL: begin
                alu_a    = hi;
                alu_b    = opnd;
                alu_oper = OP_ADD;
            end
            DIV: begin
                alu_a    = div_s;
                alu_b    = opnd;
                alu_oper = OP_SUB;
            end
            default: ;
        endcase
    end

    assign alu_wb  = 1'b0;
    assign alu_cfi = 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            opnd     <= '0;
            hi       <= '0;
            lo       <= '0;
            cnt      <= '0;
            res_lo_q <= '0;
            res_hi_q <= '0;
            dz_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        dz_q <= div_zero;
                        cnt  <= '0;
                        if (div_zero) begin
                            res_lo_q <= '1;
                            res_hi_q <= bus.a;
                        end else begin
                            opnd <= (bus.op == OP_MULU) ? bus.a : bus.b;
                            hi   <= '0;
                            lo   <= (bus.op == OP_MULU) ? bus.b : bus.a;
                        end
                    end
                end
                MUL: begin
                    hi  <= mul_hi_nx;
                    lo  <= mul_lo_nx;
                    cnt <= cnt + ITER_W'(1);
                    if (last) begin
                        res_hi_q <= mul_hi_nx;
                        res_lo_q <= mul_lo_nx;
                    end
                end
                DIV: begin
                    hi  <= div_r_nx;
                    lo  <= div_q_nx;
                    cnt <= cnt + ITER_W'(1);
                    if (last) begin
                        res_hi_q <= div_r_nx;
                        res_lo_q <= div_q_nx;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.res_lo = res_lo_q;
    assign bus.res_hi = res_hi_q;
    assign bus.dz     = dz_q;

endmodule

// File: tb/tb_mul_div_seq.sv
// Scoreboard bench for mul_div_seq with a behavioural 16-bit ALU alongside.
module tb_mul_div_seq;
    import mul_div_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mul_div_seq_if bus ();

    logic [15:0] alu_a, alu_b, alu_q;
    logic [5:0]  alu_oper;
    logic        alu_wb, alu_cfi, alu_cf;
    logic [16:0] alu_sum;

    mul_div_seq dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_oper (alu_oper),
        .alu_wb   (alu_wb),
        .alu_cfi  (alu_cfi),
        .alu_q    (alu_q),
        .alu_cf   (alu_cf)
    );

    // ALU: carry out on ADD, borrow out on SUB
    always_comb begin
        alu_sum = '0;
        case (alu_oper)
            OP_ADD:  alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
            OP_SUB:  alu_sum = {1'b0, alu_a} - {1'b0, alu_b};
            default: alu_sum = '0;
        endcase
        alu_q  = alu_sum[15:0];
        alu_cf = alu_sum[16];
    end

    typedef struct packed {
        logic [15:0] lo;
        logic [15:0] hi;
        logic        dz;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic op, input logic [15:0] a, input logic [15:0] b);
        exp_t        e;
        logic [31:0] p;
        if (op == OP_MULU) begin
            p    = 32'(a) * 32'(b);
            e.lo = p[15:0];
            e.hi = p[31:16];
            e.dz = 1'b0;
        end else if (b == 16'd0) begin
            e.lo = 16'hFFFF;
            e.hi = a;
            e.dz = 1'b1;
        end else begin
            e.lo = a / b;
            e.hi = a % b;
            e.dz = 1'b0;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                chk_eq("unexpected_done", 32'(bus.done), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk_eq("res_lo", 32'(bus.res_lo), 32'(mon_e.lo));
                chk_eq("res_hi", 32'(bus.res_hi), 32'(mon_e.hi));
                chk_eq("dz",     32'(bus.dz),     32'(mon_e.dz));
            end
        end
    end

    // Issue one operation and follow it cycle by cycle until done (bounded)
    task automatic run_op(input logic op, input logic [15:0] a, input logic [15:0] b, input bit pulse);
        exp_t       e;
        logic [5:0] exp_oper;
        int         exp_lat;
        int         lat;
        @(negedge clk);
        chk_eq("idle_busy", 32'(bus.busy), 32'd0);
        chk_eq("idle_oper", 32'(alu_oper), 32'(OP_NOP));
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        e = model(op, a, b);
        sb.push_back(e);
        exp_lat = e.dz ? 1 : 17;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = ~a;
        bus.b     = ~b;
        lat = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (pulse) bus.start = (c == 5 || c == 17);
            exp_oper = (e.dz || c == exp_lat) ? OP_NOP : ((op == OP_DIVU) ? OP_SUB : OP_ADD);
            chk_eq("busy", 32'(bus.busy), 32'd1);
            chk_eq("done", 32'(bus.done), 32'(c == exp_lat));
            chk_eq("alu_oper", 32'(alu_oper), 32'(exp_oper));
            if (bus.done === 1'b1) begin
                lat = c;
                break;
            end
        end
        chk_eq("latency", 32'(lat), 32'(exp_lat));
    endtask

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op    = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_eq("rst_busy",   32'(bus.busy),   32'd0);
        chk_eq("rst_done",   32'(bus.done),   32'd0);
        chk_eq("rst_dz",     32'(bus.dz),     32'd0);
        chk_eq("rst_res_lo", 32'(bus.res_lo), 32'd0);
        chk_eq("rst_res_hi", 32'(bus.res_hi), 32'd0);
        chk_eq("rst_oper",   32'(alu_oper),   32'(OP_NOP));

        run_op(OP_MULU, 16'h1234, 16'h5678, 1'b0);
        run_op(OP_MULU, 16'hFFFF, 16'hFFFF, 1'b0);
        run_op(OP_DIVU, 16'd1000, 16'd7,    1'b0);
        run_op(OP_DIVU, 16'hFFFF, 16'h8001, 1'b0);
        run_op(OP_DIVU, 16'hABCD, 16'h0000, 1'b0);
        run_op(OP_MULU, 16'h0000, 16'hBEEF, 1'b0);
        run_op(OP_DIVU, 16'h0005, 16'h0009, 1'b0);
        for (int i = 0; i < 6; i++) begin
            run_op(1'(i % 2), 16'($urandom), 16'($urandom_range(1, 16'hFFFF)), 1'b0);
        end

        // Ignored starts mid-operation and in DONE; next start right after
        run_op(OP_MULU, 16'h00FF, 16'h0101, 1'b1);
        run_op(OP_DIVU, 16'h8000, 16'h0003, 1'b0);

        // Reset in the middle of a divide
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = OP_DIVU;
        bus.a     = 16'h1234;
        bus.b     = 16'h0007;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_eq("mid_rst_busy",   32'(bus.busy),   32'd0);
        chk_eq("mid_rst_done",   32'(bus.done),   32'd0);
        chk_eq("mid_rst_res_lo", 32'(bus.res_lo), 32'd0);
        chk_eq("mid_rst_res_hi", 32'(bus.res_hi), 32'd0);
        chk_eq("mid_rst_dz",     32'(bus.dz),     32'd0);
        chk_eq("mid_rst_oper",   32'(alu_oper),   32'(OP_NOP));
        rst = 1'b0;
        repeat (25) @(negedge clk);
        chk_eq("post_rst_busy", 32'(bus.busy), 32'd0);

        chk_eq("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
